enet_gmii_tx_arbiter: RTL and testbench
=======================================

Name: enet_gmii_tx_arbiter

Overview:
- Shares the single GMII transmit path (gmii_tx_en/gmii_tx_er/gmii_txd into the RGMII/GMII converter) between two byte-stream frame sources.
- Round-robin arbitration per frame. Inserts 7x 0x55 preamble plus 0xD5 SFD ahead of each frame.
- Enforces a fixed inter-frame gap. Converts mid-frame source underrun into a GMII error symbol.
- Runs entirely in the GMII transmit clock domain.

Parameters:
PREAMBLE_BYTES, 7, number of 0x55 bytes before SFD (range 1..15)
IFG_BYTES, 12, idle byte-times between frames (range 1..63)

Ports:
clk  input  1  GMII transmit clock, 125 MHz
rst_n  input  1  asynchronous active-low reset
s_valid  input  2  per-source byte valid, bit i = source i
s_data  input  16  per-source byte, source i on [8i+7:8i]
s_last  input  2  per-source last byte of frame
s_ready  output  2  per-source byte accepted (combinational from state and grant)
gmii_tx_en  output  1  GMII transmit enable (registered)
gmii_tx_er  output  1  GMII transmit error (registered)
gmii_txd  output  8  GMII transmit data (registered)
grant  output  2  one-hot owner of current frame, 0 when idle
frame_done  output  1  one-cycle pulse when the last byte of a good frame is driven
underrun  output  1  one-cycle pulse when the error symbol is driven

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: gmii_tx_en=0, gmii_tx_er=0, gmii_txd=0x00, grant=0, s_ready=0, frame_done=0, underrun=0.
  - Internal: state=IDLE, last_grant=source 1, so source 0 wins first contention.
- Reset mid-frame: frame is truncated immediately on the wire (tx_en drops asynchronously). No error symbol. In-flight source handshakes are abandoned.
- GMII outputs are registered. "Load X" means X appears on gmii_* after the next clk edge.
- States: IDLE, PRE, SFD, DATA, DRAIN, IFG.
- IDLE:
  - Loads tx_en=0, txd=0x00.
  - If any s_valid: grant = the only valid source, or if both valid, the source != last_grant. Update last_grant.
  - On grant: load 0x55 with tx_en=1, set pre_cnt=1, go PRE.
  - Latency: s_valid high to first preamble byte on wire = 1 edge.
- PRE: load 0x55, increment pre_cnt. When pre_cnt reaches PREAMBLE_BYTES-1 at load time, go SFD. Total 0x55 bytes = PREAMBLE_BYTES. PREAMBLE_BYTES=1 goes IDLE->SFD directly.
- SFD: load 0xD5, go DATA.
- DATA:
  - s_ready[grant]=1, other bit 0.
  - s_valid[grant]=1: load s_data[grant] with tx_en=1, tx_er=0.
  - s_valid=1 with s_last=1: also assert frame_done aligned with that byte on the wire; go IFG.
  - s_valid[grant]=0 (underrun): load tx_en=1, tx_er=1, txd=0x00 for exactly one byte-time; pulse underrun aligned with it; go DRAIN.
- DRAIN:
  - Loads tx_en=0. s_ready[grant]=1; bytes are discarded.
  - On handshake with s_last=1: go IFG.
  - The gap counted in IFG starts after drain completes, so the wire gap is >= IFG_BYTES.
- IFG: loads tx_en=0, counts IFG_BYTES loads, then clears grant and goes IDLE. Back-to-back frames therefore show exactly IFG_BYTES idle cycles between last data byte and next 0x55.
- s_ready is 0 outside DATA/DRAIN. The non-granted source is never ready and must hold its valid; valid may be raised at any time.
- gmii_tx_er=0 except the single underrun byte.
- grant is held from the IDLE grant edge through the end of IFG.
- Counters: pre_cnt 4 bits, ifg_cnt 6 bits, both cleared on state entry. No wrap is possible within the parameter ranges.
- No minimum frame length or FCS is handled; sources provide a complete frame including padding and FCS.

Test Plan:
1. Source 0 sends a 4-byte frame 0x11,0x22,0x33,0x44 (last on 0x44) from idle -> wire shows tx_en=1 with 7x 0x55, 0xD5, 11, 22, 33, 44; frame_done on the 0x44 cycle; then tx_en=0 for 12 cycles; grant=01 throughout.
2. Both sources valid continuously with 2-byte frames -> grants alternate 01,10,01,10 starting with source 0; exactly 12 idle cycles between each last byte and the next 0x55.
3. Source 1 drops valid after 2 of 5 bytes -> wire shows those 2 bytes, then one cycle tx_en=1, tx_er=1, txd=0x00 with underrun pulse; tx_en=0 while remaining bytes drain; IFG counted after s_last is accepted; no frame_done.
4. PREAMBLE_BYTES=1, IFG_BYTES=1 build -> frame starts 0x55, 0xD5, data; single idle cycle between back-to-back frames.
5. Assert rst_n=0 mid-DATA of a frame from source 0 -> all outputs 0 immediately, grant=0; after release, source 1 alone requesting gets grant=10 with a fresh preamble.
6. Source 1 raises valid while source 0 is in PRE -> s_ready[1] stays 0 and source 1 is untouched until source 0's IFG completes; source 1 then wins.

Source files
------------

// File: rtl/enet_gmii_tx_arbiter.sv
// Two-source GMII transmit arbiter: per-frame round-robin grant, preamble/SFD
// insertion, fixed inter-frame gap and conversion of source underrun to an error symbol.
module enet_gmii_tx_arbiter #(
  parameter int unsigned PREAMBLE_BYTES = 7,
  parameter int unsigned IFG_BYTES      = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  s_valid,
  input  logic [15:0] s_data,
  input  logic [1:0]  s_last,
  output logic [1:0]  s_ready,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic [7:0]  gmii_txd,
  output logic [1:0]  grant,
  output logic        frame_done,
  output logic        underrun
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_SFD   = 3'd2,
    ST_DATA  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_IFG   = 3'd5
  } state_t;

  localparam logic [3:0] PRE_LAST   = 4'(PREAMBLE_BYTES - 1);
  localparam logic       PRE_SINGLE = (PREAMBLE_BYTES == 1);
  localparam logic [5:0] IFG_LAST   = 6'(IFG_BYTES - 1);
  localparam logic [7:0] PRE_BYTE   = 8'h55;
  localparam logic [7:0] SFD_BYTE   = 8'hD5;

  state_t      r_state;
  logic [1:0]  r_grant;
  logic        r_last_grant;
  logic [3:0]  r_pre_cnt;
  logic [5:0]  r_ifg_cnt;
  logic        r_tx_en;
  logic        r_tx_er;
  logic [7:0]  r_txd;
  logic        r_frame_done;
  logic        r_underrun;

  logic        w_src;
  logic        w_valid;
  logic        w_last;
  logic [7:0]  w_data;
  logic        w_any;
  logic        w_pick;
  logic [1:0]  w_pick_oh;

  // Granted-source view, round-robin pick and the ready strobe
  always_comb begin
    w_src   = r_grant[1];
    w_valid = s_valid[w_src];
    w_last  = s_last[w_src];
    w_data  = w_src ? s_data[15:8] : s_data[7:0];
    w_any   = |s_valid;
    // On contention the source that did not own the previous frame wins
    if (s_valid == 2'b11) begin
      w_pick = ~r_last_grant;
    end else if (s_valid[1]) begin
      w_pick = 1'b1;
    end else begin
      w_pick = 1'b0;
    end
    w_pick_oh = w_pick ? 2'b10 : 2'b01;
    if ((r_state == ST_DATA) || (r_state == ST_DRAIN)) begin
      s_ready = r_grant;
    end else begin
      s_ready = 2'b00;
    end
  end

  // Frame sequencer with registered GMII outputs and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_grant      <= 2'b00;
      r_last_grant <= 1'b1;
      r_pre_cnt    <= 4'd0;
      r_ifg_cnt    <= 6'd0;
      r_tx_en      <= 1'b0;
      r_tx_er      <= 1'b0;
      r_txd        <= 8'h00;
      r_frame_done <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_tx_er      <= 1'b0;
      r_frame_done <= 1'b0;
      r_underrun   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_tx_en   <= 1'b0;
          r_txd     <= 8'h00;
          r_pre_cnt <= 4'd0;
          r_ifg_cnt <= 6'd0;
          if (w_any) begin
            r_grant      <= w_pick_oh;
            r_last_grant <= w_pick;
            r_tx_en      <= 1'b1;
            r_txd        <= PRE_BYTE;
            r_pre_cnt    <= 4'd1;
            r_state      <= PRE_SINGLE ? ST_SFD : ST_PRE;
          end else begin
            r_grant <= 2'b00;
          end
        end
        ST_PRE: begin
          r_tx_en   <= 1'b1;
          r_txd     <= PRE_BYTE;
          r_pre_cnt <= r_pre_cnt + 4'd1;
          if (r_pre_cnt == PRE_LAST) begin
            r_state <= ST_SFD;
          end else begin
            r_state <= ST_PRE;
          end
        end
        ST_SFD: begin
          r_tx_en <= 1'b1;
          r_txd   <= SFD_BYTE;
          r_state <= ST_DATA;
        end
        ST_DATA: begin
          r_tx_en <= 1'b1;
          if (w_valid) begin
            r_txd <= w_data;
            if (w_last) begin
              r_frame_done <= 1'b1;
              r_ifg_cnt    <= 6'd0;
              r_state      <= ST_IFG;
            end else begin
              r_state <= ST_DATA;
            end
          end else begin
            // Source starved mid-frame: one error symbol, then swallow the rest
            r_tx_er    <= 1'b1;
            r_txd      <= 8'h00;
            r_underrun <= 1'b1;
            r_state    <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          r_tx_en <= 1'b0;
          r_txd   <= 8'h00;
          if (w_valid && w_last) begin
            r_ifg_cnt <= 6'd0;
            r_state   <= ST_IFG;
          end else begin
            r_state <= ST_DRAIN;
          end
        end
        ST_IFG: begin
          r_tx_en <= 1'b0;
          r_txd   <= 8'h00;
          if (r_ifg_cnt == IFG_LAST) begin
            r_grant   <= 2'b00;
            r_ifg_cnt <= 6'd0;
            r_state   <= ST_IDLE;
          end else begin
            r_ifg_cnt <= r_ifg_cnt + 6'd1;
            r_state   <= ST_IFG;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= 2'b00;
          r_tx_en <= 1'b0;
          r_txd   <= 8'h00;
        end
      endcase
    end
  end

  assign gmii_tx_en = r_tx_en;
  assign gmii_tx_er = r_tx_er;
  assign gmii_txd   = r_txd;
  assign grant      = r_grant;
  assign frame_done = r_frame_done;
  assign underrun   = r_underrun;

endmodule

// File: tb/tb_enet_gmii_tx_arbiter.sv
// Directed bench for enet_gmii_tx_arbiter: default build plus a 1-byte preamble /
// 1-byte IFG build, wire activity logged per cycle and compared to hand-built tables.
module tb_enet_gmii_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  m_valid, m_last, m_ready, m_grant;
  logic [15:0] m_data;
  logic        m_en, m_er, m_fd, m_ur;
  logic [7:0]  m_txd;
  logic [1:0]  b_valid, b_last, b_ready, b_grant;
  logic [15:0] b_data;
  logic        b_en, b_er, b_fd, b_ur;
  logic [7:0]  b_txd;

  logic        sel_b;
  logic [8:0]  q0[$];
  logic [8:0]  q1[$];
  logic [15:0] lg [0:127];
  int          lg_n;
  int          n_total;
  int          n_bad;

  enet_gmii_tx_arbiter #(.PREAMBLE_BYTES(7), .IFG_BYTES(12)) u_dut (
    .clk(clk), .rst_n(rst_n), .s_valid(m_valid), .s_data(m_data), .s_last(m_last),
    .s_ready(m_ready), .gmii_tx_en(m_en), .gmii_tx_er(m_er), .gmii_txd(m_txd),
    .grant(m_grant), .frame_done(m_fd), .underrun(m_ur)
  );

  enet_gmii_tx_arbiter #(.PREAMBLE_BYTES(1), .IFG_BYTES(1)) u_dut_min (
    .clk(clk), .rst_n(rst_n), .s_valid(b_valid), .s_data(b_data), .s_last(b_last),
    .s_ready(b_ready), .gmii_tx_en(b_en), .gmii_tx_er(b_er), .gmii_txd(b_txd),
    .grant(b_grant), .frame_done(b_fd), .underrun(b_ur)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [15:0] pk(input logic en, input logic er, input logic [7:0] d,
                                      input logic fd, input logic ur, input logic [1:0] g,
                                      input logic [1:0] r);
    return {en, er, d, fd, ur, g, r};
  endfunction

  task automatic drive();
    logic [1:0]  v;
    logic [15:0] d;
    logic [1:0]  l;
    v = 2'b00; d = 16'h0000; l = 2'b00;
    if (q0.size() > 0) begin v[0] = 1'b1; d[7:0]  = q0[0][7:0]; l[0] = q0[0][8]; end
    if (q1.size() > 0) begin v[1] = 1'b1; d[15:8] = q1[0][7:0]; l[1] = q1[0][8]; end
    if (sel_b) begin
      b_valid = v; b_data = d; b_last = l;
      m_valid = 2'b00; m_data = 16'h0000; m_last = 2'b00;
    end else begin
      m_valid = v; m_data = d; m_last = l;
      b_valid = 2'b00; b_data = 16'h0000; b_last = 2'b00;
    end
  endtask

  // Log the wire at the falling edge, then advance sources on handshakes
  task automatic tick();
    logic [1:0] hs;
    @(negedge clk);
    if (sel_b) begin
      hs = b_valid & b_ready;
      if (lg_n < 128) lg[lg_n] = {b_en, b_er, b_txd, b_fd, b_ur, b_grant, b_ready};
    end else begin
      hs = m_valid & m_ready;
      if (lg_n < 128) lg[lg_n] = {m_en, m_er, m_txd, m_fd, m_ur, m_grant, m_ready};
    end
    lg_n++;
    @(posedge clk);
    #1;
    if (hs[0] && (q0.size() > 0)) q0.delete(0);
    if (hs[1] && (q1.size() > 0)) q1.delete(0);
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sel_b = 1'b0;
    q0.delete();
    q1.delete();
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    lg_n = 0;
  endtask

  task automatic test_reset();
    logic [15:0] obs;
    rst_n = 1'b0;
    #1;
    obs = {m_en, m_er, m_txd, m_fd, m_ur, m_grant, m_ready};
    n_total++;
    if (obs !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_held got=%h exp=0000", obs);
    end
    do_reset();
    repeat (3) tick();
    n_total++;
    if (lg[2] !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_idle got=%h exp=0000", lg[2]);
    end
  endtask

  task automatic test_single_frame();
    logic [15:0] e [0:127];
    logic [7:0]  d [0:3];
    d = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    for (int i = 0; i < 4; i++) q0.push_back({(i == 3), d[i]});
    drive();
    repeat (30) tick();
    for (int k = 0; k < 30; k++)
      e[k] = pk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, ((k >= 1) && (k <= 23)) ? 2'b01 : 2'b00, 2'b00);
    for (int k = 1; k <= 7; k++) e[k] = pk(1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 2'b01, 2'b00);
    e[8] = pk(1'b1, 1'b0, 8'hD5, 1'b0, 1'b0, 2'b01, 2'b01);
    for (int i = 0; i < 4; i++)
      e[9+i] = pk(1'b1, 1'b0, d[i], (i == 3), 1'b0, 2'b01, (i < 3) ? 2'b01 : 2'b00);
    for (int k = 0; k < 30; k++) begin
      n_total++;
      if (lg[k] !== e[k]) begin
        n_bad++;
        $display("FAIL single_frame[%0d] got=%h exp=%h", k, lg[k], e[k]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] e [0:127];
    int          s;
    logic [1:0]  g;
    logic [7:0]  d0;
    do_reset();
    q0.push_back({1'b0, 8'h10}); q0.push_back({1'b1, 8'h11});
    q0.push_back({1'b0, 8'h12}); q0.push_back({1'b1, 8'h13});
    q1.push_back({1'b0, 8'h20}); q1.push_back({1'b1, 8'h21});
    q1.push_back({1'b0, 8'h22}); q1.push_back({1'b1, 8'h23});
    drive();
    repeat (90) tick();
    for (int k = 0; k < 90; k++) e[k] = 16'h0000;
    for (int f = 0; f < 4; f++) begin
      s  = 1 + 22 * f;
      g  = ((f % 2) == 1) ? 2'b10 : 2'b01;
      d0 = (((f % 2) == 1) ? 8'h20 : 8'h10) + ((f >= 2) ? 8'h02 : 8'h00);
      for (int k = s; k <= s + 20; k++) e[k] = pk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, g, 2'b00);
      for (int k = s; k <= s + 6; k++) e[k] = pk(1'b1, 1'b0, 8'h55, 1'b0, 1'b0, g, 2'b00);
      e[s+7] = pk(1'b1, 1'b0, 8'hD5, 1'b0, 1'b0, g, g);
      e[s+8] = pk(1'b1, 1'b0, d0, 1'b0, 1'b0, g, g);
      e[s+9] = pk(1'b1, 1'b0, d0 + 8'h01, 1'b1, 1'b0, g, 2'b00);
    end
    for (int k = 0; k < 90; k++) begin
      n_total++;
      if (lg[k] !== e[k]) begin
        n_bad++;
        $display("FAIL round_robin[%0d] got=%h exp=%h", k, lg[k], e[k]);
      end
    end
  endtask

  task automatic test_underrun();
    logic [15:0] e [0:127];
    do_reset();
    q1.push_back({1'b0, 8'hA1}); q1.push_back({1'b0, 8'hA2});
    drive();
    repeat (12) tick();
    q1.push_back({1'b0, 8'hA3}); q1.push_back({1'b0, 8'hA4}); q1.push_back({1'b1, 8'hA5});
    drive();
    repeat (20) tick();
    for (int k = 0; k < 32; k++)
      e[k] = pk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, ((k >= 1) && (k <= 26)) ? 2'b10 : 2'b00,
                ((k >= 8) && (k <= 14)) ? 2'b10 : 2'b00);
    for (int k = 1; k <= 7; k++) e[k] = pk(1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 2'b10, 2'b00);
    e[8]  = pk(1'b1, 1'b0, 8'hD5, 1'b0, 1'b0, 2'b10, 2'b10);
    e[9]  = pk(1'b1, 1'b0, 8'hA1, 1'b0, 1'b0, 2'b10, 2'b10);
    e[10] = pk(1'b1, 1'b0, 8'hA2, 1'b0, 1'b0, 2'b10, 2'b10);
    e[11] = pk(1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 2'b10, 2'b10);
    for (int k = 0; k < 32; k++) begin
      n_total++;
      if (lg[k] !== e[k]) begin
        n_bad++;
        $display("FAIL underrun[%0d] got=%h exp=%h", k, lg[k], e[k]);
      end
    end
    n_total++;
    if (q1.size() != 0) begin
      n_bad++;
      $display("FAIL underrun_drained left=%0d exp=0", q1.size());
    end
  endtask

  task automatic test_min_params();
    logic [15:0] e [0:127];
    do_reset();
    sel_b = 1'b1;
    q0.push_back({1'b0, 8'h31}); q0.push_back({1'b1, 8'h32}); q0.push_back({1'b1, 8'h33});
    drive();
    repeat (11) tick();
    for (int k = 0; k < 11; k++) e[k] = 16'h0000;
    e[1] = pk(1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 2'b01, 2'b00);
    e[2] = pk(1'b1, 1'b0, 8'hD5, 1'b0, 1'b0, 2'b01, 2'b01);
    e[3] = pk(1'b1, 1'b0, 8'h31, 1'b0, 1'b0, 2'b01, 2'b01);
    e[4] = pk(1'b1, 1'b0, 8'h32, 1'b1, 1'b0, 2'b01, 2'b00);
    e[6] = pk(1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 2'b01, 2'b00);
    e[7] = pk(1'b1, 1'b0, 8'hD5, 1'b0, 1'b0, 2'b01, 2'b01);
    e[8] = pk(1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 2'b01, 2'b00);
    for (int k = 0; k < 11; k++) begin
      n_total++;
      if (lg[k] !== e[k]) begin
        n_bad++;
        $display("FAIL min_params[%0d] got=%h exp=%h", k, lg[k], e[k]);
      end
    end
    sel_b = 1'b0;
    drive();
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] e [0:127];
    logic [15:0] obs;
    do_reset();
    for (int i = 0; i < 5; i++) q0.push_back({(i == 4), 8'h41 + 8'(i)});
    drive();
    repeat (10) tick();
    n_total++;
    if (lg[9] !== pk(1'b1, 1'b0, 8'h41, 1'b0, 1'b0, 2'b01, 2'b01)) begin
      n_bad++;
      $display("FAIL mid_reset_pre got=%h exp=%h", lg[9], pk(1'b1, 1'b0, 8'h41, 1'b0, 1'b0, 2'b01, 2'b01));
    end
    #2;
    rst_n = 1'b0;
    #1;
    obs = {m_en, m_er, m_txd, m_fd, m_ur, m_grant, m_ready};
    n_total++;
    if (obs !== 16'h0000) begin
      n_bad++;
      $display("FAIL mid_reset_async got=%h exp=0000", obs);
    end
    q0.delete();
    drive();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    lg_n = 0;
    q1.push_back({1'b1, 8'h51});
    drive();
    repeat (11) tick();
    for (int k = 0; k < 11; k++)
      e[k] = pk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, (k >= 1) ? 2'b10 : 2'b00, 2'b00);
    for (int k = 1; k <= 7; k++) e[k] = pk(1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 2'b10, 2'b00);
    e[8] = pk(1'b1, 1'b0, 8'hD5, 1'b0, 1'b0, 2'b10, 2'b10);
    e[9] = pk(1'b1, 1'b0, 8'h51, 1'b1, 1'b0, 2'b10, 2'b00);
    for (int k = 0; k < 11; k++) begin
      n_total++;
      if (lg[k] !== e[k]) begin
        n_bad++;
        $display("FAIL mid_reset_restart[%0d] got=%h exp=%h", k, lg[k], e[k]);
      end
    end
  endtask

  task automatic test_late_request();
    logic [15:0] e [0:127];
    logic [1:0]  g;
    do_reset();
    q0.push_back({1'b0, 8'h61}); q0.push_back({1'b1, 8'h62});
    drive();
    repeat (3) tick();
    q1.push_back({1'b1, 8'h71});
    drive();
    repeat (31) tick();
    for (int k = 0; k < 34; k++) begin
      g = ((k >= 1) && (k <= 21)) ? 2'b01 : ((k >= 23) ? 2'b10 : 2'b00);
      e[k] = pk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, g, 2'b00);
    end
    for (int k = 1; k <= 7; k++) e[k] = pk(1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 2'b01, 2'b00);
    e[8]  = pk(1'b1, 1'b0, 8'hD5, 1'b0, 1'b0, 2'b01, 2'b01);
    e[9]  = pk(1'b1, 1'b0, 8'h61, 1'b0, 1'b0, 2'b01, 2'b01);
    e[10] = pk(1'b1, 1'b0, 8'h62, 1'b1, 1'b0, 2'b01, 2'b00);
    for (int k = 23; k <= 29; k++) e[k] = pk(1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 2'b10, 2'b00);
    e[30] = pk(1'b1, 1'b0, 8'hD5, 1'b0, 1'b0, 2'b10, 2'b10);
    e[31] = pk(1'b1, 1'b0, 8'h71, 1'b1, 1'b0, 2'b10, 2'b00);
    for (int k = 0; k < 34; k++) begin
      n_total++;
      if (lg[k] !== e[k]) begin
        n_bad++;
        $display("FAIL late_request[%0d] got=%h exp=%h", k, lg[k], e[k]);
      end
    end
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    lg_n    = 0;
    rst_n   = 1'b0;
    sel_b   = 1'b0;
    drive();
    test_reset();
    test_single_frame();
    test_round_robin();
    test_underrun();
    test_min_params();
    test_reset_mid_frame();
    test_late_request();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
